// File: rtl/edge_capture_pkg.sv
// Shared types for the edge capture block: filter FSM states and the event record.
package edge_capture_pkg;

    localparam int unsigned QCNT_W   = 8;
    localparam int unsigned TS_W_MAX = 32;

    typedef enum logic {
        STABLE = 1'b0,
        QUAL   = 1'b1
    } filt_state_t;

    // Widest event record; the block's own TS_W must not exceed TS_W_MAX
    typedef struct packed {
        logic                level;
        logic [TS_W_MAX-1:0] ts;
    } ev_rec_t;

endpackage

// File: rtl/edge_capture_q_if.sv
// Level input, filtered output and event-queue handshake of edge_capture_q.
interface edge_capture_q_if #(
    parameter int unsigned TS_W  = 16,
    parameter int unsigned DEPTH = 8
);
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    logic             in;
    logic             out;
    logic             ev_valid;
    logic             ev_ready;
    logic             ev_level;
    logic [TS_W-1:0]  ev_time;
    logic [CNT_W-1:0] ev_count;
    logic             overflow;

    modport master (
        input  in, ev_ready,
        output out, ev_valid, ev_level, ev_time, ev_count, overflow
    );

    modport slave (
        output in, ev_ready,
        input  out, ev_valid, ev_level, ev_time, ev_count, overflow
    );
endinterface

// File: rtl/event_fifo.sv
// Event queue: DEPTH-entry FIFO with head shown from storage and a sticky drop flag.
module event_fifo #(
    parameter int unsigned W     = 17,
    parameter int unsigned DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_push,
    input  logic [W-1:0]               i_data,
    input  logic                       i_pop,
    output logic [W-1:0]               o_data,
    output logic                       o_valid,
    output logic [$clog2(DEPTH):0]     o_count,
    output logic                       o_overflow
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          r_overflow;

    logic w_full;
    logic w_pop;
    logic w_wr;

    // A pop frees a slot in the same edge, so a full queue can still accept a push
    assign w_full = (r_count == CW'(DEPTH));
    assign w_pop  = i_pop && (r_count != '0);
    assign w_wr   = i_push && (!w_full || w_pop);

    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_wr, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
            if (i_push && w_full && !w_pop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    assign o_data     = r_mem[r_rd_ptr];
    assign o_valid    = (r_count != '0);
    assign o_count    = r_count;
    assign o_overflow = r_overflow;

endmodule

// File: rtl/edge_capture_q.sv
// Synchronizes and debounces an asynchronous level, timestamping each accepted
// change into an event queue.
module edge_capture_q
    import edge_capture_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned FILT_CYCLES = 4,
    parameter int unsigned TS_W        = 16,
    parameter int unsigned DEPTH       = 8,
    parameter logic        INIT_V      = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    edge_capture_q_if.master  bus
);
    typedef struct packed {
        logic            level;
        logic [TS_W-1:0] ts;
    } ev_t;

    localparam int unsigned EV_W = $bits(ev_t);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   w_sin;
    filt_state_t            r_state;
    logic [QCNT_W-1:0]      r_qual_cnt;
    logic                   r_out;
    logic [TS_W-1:0]        r_ts;
    logic [TS_W-1:0]        w_ts_next;
    logic                   w_diff;
    logic                   w_accept;
    ev_t                    w_wr_ev;
    ev_t                    w_head_ev;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync <= {SYNC_STAGES{INIT_V}};
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], bus.in};
        end
    end

    assign w_sin     = r_sync[SYNC_STAGES-1];
    assign w_diff    = (w_sin != r_out);
    assign w_ts_next = r_ts + TS_W'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ts <= '0;
        end else begin
            r_ts <= w_ts_next;
        end
    end

    // A single-cycle filter accepts straight from STABLE; otherwise QUAL counts to FILT_CYCLES-1
    assign w_accept = w_diff &&
                      (((r_state == STABLE) && (FILT_CYCLES == 1)) ||
                       ((r_state == QUAL) && (r_qual_cnt == QCNT_W'(FILT_CYCLES - 1))));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= STABLE;
            r_qual_cnt <= '0;
            r_out      <= INIT_V;
        end else begin
            case (r_state)
                STABLE: begin
                    if (w_accept) begin
                        r_out <= w_sin;
                    end else if (w_diff) begin
                        r_state    <= QUAL;
                        r_qual_cnt <= QCNT_W'(1);
                    end
                end
                QUAL: begin
                    if (!w_diff) begin
                        r_state    <= STABLE;
                        r_qual_cnt <= '0;
                    end else if (w_accept) begin
                        r_out      <= w_sin;
                        r_state    <= STABLE;
                        r_qual_cnt <= '0;
                    end else begin
                        r_qual_cnt <= r_qual_cnt + QCNT_W'(1);
                    end
                end
                default: begin
                    r_state    <= STABLE;
                    r_qual_cnt <= '0;
                end
            endcase
        end
    end

    // Timestamp is the counter value in the cycle the new level first appears on out
    assign w_wr_ev = '{level: ~r_out, ts: w_ts_next};

    event_fifo #(
        .W     (EV_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .i_push     (w_accept),
        .i_data     (w_wr_ev),
        .i_pop      (bus.ev_ready),
        .o_data     (w_head_ev),
        .o_valid    (bus.ev_valid),
        .o_count    (bus.ev_count),
        .o_overflow (bus.overflow)
    );

    assign bus.out      = r_out;
    assign bus.ev_level = w_head_ev.level;
    assign bus.ev_time  = w_head_ev.ts;

endmodule

// File: tb/tb_edge_capture_q.sv
// Directed bench for edge_capture_q: latency, glitch rejection, queue fill/overflow,
// full push+pop, timestamp wrap and mid-qualification reset.
module tb_edge_capture_q;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    edge_capture_q_if #(.TS_W(16), .DEPTH(8)) bus_a ();
    edge_capture_q_if #(.TS_W(4),  .DEPTH(8)) bus_b ();

    edge_capture_q #(
        .SYNC_STAGES(2), .FILT_CYCLES(4), .TS_W(16), .DEPTH(8), .INIT_V(1'b0)
    ) u_a (
        .clk (clk),
        .rst (rst),
        .bus (bus_a)
    );

    edge_capture_q #(
        .SYNC_STAGES(2), .FILT_CYCLES(4), .TS_W(4), .DEPTH(8), .INIT_V(1'b0)
    ) u_b (
        .clk (clk),
        .rst (rst),
        .bus (bus_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_chk++;
        assert (obs === expv)
        else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, expv, cyc);
        end
    endtask

    // One clock: inputs and samples both sit 1 time unit after the rising edge
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic goto(input int c);
        while (cyc < c) step();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        cyc = 0;
    endtask

    initial begin
        bus_a.in = 1'b0; bus_a.ev_ready = 1'b0;
        bus_b.in = 1'b0; bus_b.ev_ready = 1'b0;

        // Reset state
        #2;
        chk("rst_async_out", 32'(bus_a.out), 32'd0);
        chk("rst_async_valid", 32'(bus_a.ev_valid), 32'd0);
        do_reset();
        chk("rst_out", 32'(bus_a.out), 32'd0);
        chk("rst_valid", 32'(bus_a.ev_valid), 32'd0);
        chk("rst_count", 32'(bus_a.ev_count), 32'd0);
        chk("rst_ovf", 32'(bus_a.overflow), 32'd0);

        // Clean step latency on A, 4-bit timestamp wrap on B
        goto(9);  bus_b.in = 1'b1;
        goto(10); bus_a.in = 1'b1;
        goto(13); bus_b.in = 1'b0;
        goto(15);
        chk("step_out_early", 32'(bus_a.out), 32'd0);
        chk("wrap_first_ts", 32'(bus_b.ev_time), 32'd15);
        chk("wrap_first_lvl", 32'(bus_b.ev_level), 32'd1);
        goto(16);
        chk("step_out", 32'(bus_a.out), 32'd1);
        chk("step_valid", 32'(bus_a.ev_valid), 32'd1);
        chk("step_count", 32'(bus_a.ev_count), 32'd1);
        chk("step_level", 32'(bus_a.ev_level), 32'd1);
        chk("step_time", 32'(bus_a.ev_time), 32'd16);
        bus_a.ev_ready = 1'b1;
        step();
        bus_a.ev_ready = 1'b0;
        chk("pop_count", 32'(bus_a.ev_count), 32'd0);
        chk("pop_valid", 32'(bus_a.ev_valid), 32'd0);
        goto(19);
        chk("wrap_count", 32'(bus_b.ev_count), 32'd2);
        bus_b.ev_ready = 1'b1;
        step();
        bus_b.ev_ready = 1'b0;
        chk("wrap_second_ts", 32'(bus_b.ev_time), 32'd3);
        chk("wrap_second_lvl", 32'(bus_b.ev_level), 32'd0);
        chk("wrap_after_pop", 32'(bus_b.ev_count), 32'd1);
        bus_a.ev_ready = 1'b1;
        step(); step();
        bus_a.ev_ready = 1'b0;
        chk("empty_ready_count", 32'(bus_a.ev_count), 32'd0);
        chk("empty_ready_ovf", 32'(bus_a.overflow), 32'd0);

        // Glitch rejection: 3-cycle pulse dropped, 4-cycle pulse accepted
        bus_a.in = 1'b0; bus_b.in = 1'b0;
        do_reset();
        goto(10); bus_a.in = 1'b1;
        goto(13); bus_a.in = 1'b0;
        goto(25);
        chk("glitch_out", 32'(bus_a.out), 32'd0);
        chk("glitch_valid", 32'(bus_a.ev_valid), 32'd0);
        chk("glitch_ovf", 32'(bus_a.overflow), 32'd0);
        goto(30); bus_a.in = 1'b1;
        goto(34); bus_a.in = 1'b0;
        goto(35);
        chk("pulse4_out_early", 32'(bus_a.out), 32'd0);
        goto(36);
        chk("pulse4_out", 32'(bus_a.out), 32'd1);
        chk("pulse4_time", 32'(bus_a.ev_time), 32'd36);

        // Nine edges with no consumer: eight queued, ninth dropped
        bus_a.in = 1'b0;
        do_reset();
        for (int k = 0; k < 9; k++) begin
            goto(10 + 10 * k);
            if (k == 8) begin
                chk("fill_count8", 32'(bus_a.ev_count), 32'd8);
                chk("fill_ovf_before", 32'(bus_a.overflow), 32'd0);
            end
            bus_a.in = ~bus_a.in;
        end
        goto(97);
        chk("drop_count", 32'(bus_a.ev_count), 32'd8);
        chk("drop_ovf", 32'(bus_a.overflow), 32'd1);
        chk("drop_out", 32'(bus_a.out), 32'd1);
        bus_a.ev_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            chk("drain_level", 32'(bus_a.ev_level), (i % 2 == 0) ? 32'd1 : 32'd0);
            chk("drain_time", 32'(bus_a.ev_time), 32'(16 + 10 * i));
            step();
        end
        bus_a.ev_ready = 1'b0;
        chk("drain_empty", 32'(bus_a.ev_valid), 32'd0);
        chk("drain_ovf_sticky", 32'(bus_a.overflow), 32'd1);

        // Full queue: push and pop in the same edge
        bus_a.in = 1'b0;
        do_reset();
        for (int k = 0; k < 9; k++) begin
            goto(10 + 10 * k);
            bus_a.in = ~bus_a.in;
        end
        goto(95);
        bus_a.ev_ready = 1'b1;
        step();
        bus_a.ev_ready = 1'b0;
        chk("fullpp_count", 32'(bus_a.ev_count), 32'd8);
        chk("fullpp_ovf", 32'(bus_a.overflow), 32'd0);
        chk("fullpp_head_time", 32'(bus_a.ev_time), 32'd26);
        chk("fullpp_head_lvl", 32'(bus_a.ev_level), 32'd0);
        bus_a.ev_ready = 1'b1;
        repeat (7) step();
        bus_a.ev_ready = 1'b0;
        chk("fullpp_tail_time", 32'(bus_a.ev_time), 32'd96);
        chk("fullpp_tail_lvl", 32'(bus_a.ev_level), 32'd1);
        chk("fullpp_tail_count", 32'(bus_a.ev_count), 32'd1);

        // Partial queue: push and pop together leave the count unchanged
        bus_a.in = 1'b0;
        do_reset();
        goto(10); bus_a.in = 1'b1;
        goto(20); bus_a.in = 1'b0;
        goto(25);
        bus_a.ev_ready = 1'b1;
        step();
        bus_a.ev_ready = 1'b0;
        chk("midpp_count", 32'(bus_a.ev_count), 32'd1);
        chk("midpp_time", 32'(bus_a.ev_time), 32'd26);
        chk("midpp_level", 32'(bus_a.ev_level), 32'd0);

        // Reset during qualification with three events queued
        bus_a.in = 1'b0;
        do_reset();
        goto(10); bus_a.in = 1'b1;
        goto(20); bus_a.in = 1'b0;
        goto(30); bus_a.in = 1'b1;
        goto(40); bus_a.in = 1'b0;
        goto(44);
        chk("pre_rst_count", 32'(bus_a.ev_count), 32'd3);
        chk("pre_rst_out", 32'(bus_a.out), 32'd1);
        rst = 1'b1;
        #1;
        chk("midrst_out", 32'(bus_a.out), 32'd0);
        chk("midrst_valid", 32'(bus_a.ev_valid), 32'd0);
        chk("midrst_count", 32'(bus_a.ev_count), 32'd0);
        do_reset();
        goto(10); bus_a.in = 1'b1;
        goto(15);
        chk("post_rst_early", 32'(bus_a.ev_valid), 32'd0);
        goto(16);
        chk("post_rst_time", 32'(bus_a.ev_time), 32'd16);
        chk("post_rst_count", 32'(bus_a.ev_count), 32'd1);
        chk("post_rst_ovf", 32'(bus_a.overflow), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/edge_capture_q.md
EDGE_CAPTURE_Q -- requirements
Module: edge_capture_q

Interface
REQ-001 Parameter SYNC_STAGES, default 2: synchronizer flops on `in`; legal range 2..4.
REQ-002 Parameter FILT_CYCLES, default 4: consecutive stable cycles needed to accept a new level; legal range 1..255.
REQ-003 Parameter TS_W, default 16: timestamp width.
REQ-004 Parameter DEPTH, default 8: event queue depth; power of two, minimum 2.
REQ-005 Parameter INIT_V, default 0: reset value of `out` and of the synchronizer chain.
REQ-006 The block SHALL use one clock; reset is asynchronous and active-high.
REQ-007 clk  input  1  rising-edge clock.
REQ-008 rst  input  1  asynchronous active-high reset.
REQ-009 in  input  1  asynchronous digital level from the upstream inverter's output (`out`).
REQ-010 out  output  1  filtered, synchronized level.
REQ-011 ev_valid  output  1  queue head holds an event.
REQ-012 ev_ready  input  1  consumer accepts the head event.
REQ-013 ev_level  output  1  new level of the head event.
REQ-014 ev_time  output  TS_W  timestamp of the head event.
REQ-015 ev_count  output  log2(DEPTH)+1  queue occupancy.
REQ-016 overflow  output  1  sticky flag: an event was dropped.

Function
REQ-017 `in` SHALL pass through SYNC_STAGES flops; `sin` is the last stage.
REQ-018 A filter FSM SHALL have two states: STABLE and QUAL.
- STABLE: when sin != out, load qual_cnt=1 and go to QUAL.
- QUAL: when sin == out, go to STABLE with no event.
- QUAL: when sin != out and qual_cnt == FILT_CYCLES-1, toggle out, push an event and go to STABLE.
- QUAL otherwise: increment qual_cnt.
REQ-019 With FILT_CYCLES=1, STABLE SHALL accept the change directly in the cycle it sees sin != out.
REQ-020 `out` SHALL follow a clean step on `in` exactly SYNC_STAGES+FILT_CYCLES rising edges after the step is sampled.
REQ-021 A pulse held stable for fewer than FILT_CYCLES cycles at `sin` SHALL produce no `out` change and no event.
REQ-022 A free-running TS_W counter SHALL increment every cycle and wrap from 2^TS_W-1 to 0.
REQ-023 The event payload SHALL be {new out value, counter value in the cycle the toggle is registered}.
REQ-024 Events SHALL be queued in a FIFO of DEPTH entries and delivered in order.
- ev_valid = (count != 0).
- ev_level and ev_time SHALL show the head entry combinationally from storage.
REQ-025 A pop SHALL occur on a rising edge where ev_valid && ev_ready are both high; ev_ready while empty SHALL have no effect.
REQ-026 A push into a full queue with no simultaneous pop SHALL be dropped and SHALL set overflow; queue contents SHALL be unchanged.
REQ-027 A simultaneous push and pop while full SHALL accept the push, with count remaining DEPTH.
REQ-028 A simultaneous push and pop while empty is impossible, because a pop requires ev_valid.
REQ-029 A simultaneous push and pop at 0 < count < DEPTH SHALL leave count unchanged.
REQ-030 Read and write pointers SHALL wrap modulo DEPTH.

Reset
REQ-031 On rst=1, asynchronously:
- synchronizer flops and out = INIT_V
- FSM = STABLE, qual_cnt = 0
- timestamp = 0
- pointers and count = 0, so ev_valid = 0
- overflow = 0
REQ-032 Assertion of rst mid-qualification or with a non-empty queue SHALL discard all pending state and events.
REQ-033 After rst deasserts, the first accepted edge SHALL be timestamped relative to counter 0.
REQ-034 overflow SHALL clear only on rst.

Structure
REQ-035 A shared package edge_capture_pkg SHALL hold the FSM state enum {STABLE, QUAL} and the event record typedef {level, time}, with the time field parameterized via TS_W.
REQ-036 The FIFO SHALL be one sub-module, event_fifo, parameterized by width and DEPTH.
- The synchronizer, filter FSM and timestamp counter SHALL stay in edge_capture_q.

Verification
REQ-037 Reset, then `in` 0->1 at cycle 10, defaults -> out rises at cycle 16; one event {1, ts=16} with ev_valid=1 and ev_count=1.
REQ-038 A 3-cycle high glitch on `in` with FILT_CYCLES=4 -> out stays 0, ev_valid stays 0, overflow=0.
REQ-039 Nine clean edges with ev_ready=0 and DEPTH=8:
- first eight queued, ev_count=8
- ninth dropped, overflow=1
- then ev_ready=1 drains the eight events in order with increasing ts.
REQ-040 Queue full and an accepted edge in the same cycle as ev_ready=1 -> head popped, new event appended, ev_count stays 8, overflow unchanged.
REQ-041 With TS_W=4, an edge accepted at counter value 15 and the next at 19 cycles from reset -> ev_time 15 then 3 (wrap).
REQ-042 rst pulsed while in QUAL with 3 queued events -> out=INIT_V, ev_valid=0, ev_count=0, timestamp restarts at 0.
